// File: rtl/wbs_decoder_pkg.sv
// wbs_decoder_pkg: FSM state encodings and default parameter values shared by the decoder files
package wbs_decoder_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;
    localparam int NUM_SLAVES_DEF = 8;
    localparam int DEC_BITS_DEF   = 3;
    localparam int TIMEOUT_DEF    = 1023;
    localparam int TO_BITS_DEF    = 10;
endpackage

// File: rtl/wbs_timeout_cnt.sv
// wbs_timeout_cnt: busy-cycle counter that flags when TIMEOUT cycles have elapsed
//   clk     in  bus clock
//   rst_n   in  synchronous reset, active-low
//   clr     in  clear count (held while the decoder is not busy)
//   en      in  count enable (one increment per busy cycle)
//   expired out count has reached TIMEOUT
module wbs_timeout_cnt #(
    parameter int TO_BITS = 10,
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [TO_BITS-1:0] cnt;
    assign expired = cnt == TO_BITS'(TIMEOUT);
    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/wbs_decoder.sv
// wbs_decoder: Wishbone slave-side decoder; forwards one arbiter request to the slave picked by adr[15:16-DEC_BITS]
//   wb_clk_i/wb_rst_n_i       clock and synchronous active-low reset
//   wbm_cyc_i/stb_i/we_i/sel_i/adr_i/dat_i   single-cycle request from the arbiter
//   wbm_dat_o/ack_o/err_o     registered response pulse to the arbiter
//   wbs_cyc_o/stb_o           one-hot request to the selected slave, held until it answers
//   wbs_we_o/sel_o/adr_o/dat_o latched request fields
//   wbs_dat_i/ack_i/err_i     slave responses, slave k at data bits [16k+15:16k]
//   Build option: define WBS_DECODER_TIMEOUT_EN to force err after TIMEOUT silent busy cycles.
module wbs_decoder
    import wbs_decoder_pkg::*;
#(
    parameter int NUM_SLAVES = NUM_SLAVES_DEF,
    parameter int DEC_BITS   = DEC_BITS_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int TO_BITS    = TO_BITS_DEF
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n_i,
    input  logic                     wbm_cyc_i,
    input  logic                     wbm_stb_i,
    input  logic                     wbm_we_i,
    input  logic [1:0]               wbm_sel_i,
    input  logic [31:0]              wbm_adr_i,
    input  logic [15:0]              wbm_dat_i,
    output logic [15:0]              wbm_dat_o,
    output logic                     wbm_ack_o,
    output logic                     wbm_err_o,
    output logic [NUM_SLAVES-1:0]    wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]    wbs_stb_o,
    output logic                     wbs_we_o,
    output logic [1:0]               wbs_sel_o,
    output logic [15:0]              wbs_adr_o,
    output logic [15:0]              wbs_dat_o,
    input  logic [16*NUM_SLAVES-1:0] wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]    wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]    wbs_err_i
);
    if (NUM_SLAVES < 1 || NUM_SLAVES > 2**DEC_BITS || 2**TO_BITS <= TIMEOUT) begin : g_bad_cfg
        $error("wbs_decoder: illegal parameter combination");
    end
    logic [1:0]            state;
    logic [DEC_BITS-1:0]   dec_idx;
    logic [NUM_SLAVES-1:0] dec_oh;
    logic [15:0]           rd_dat;
    logic                  req, hit, s_ack, s_err, to_exp, unused_adr;
    assign req        = wbm_cyc_i & wbm_stb_i;
    assign dec_idx    = wbm_adr_i[15:16-DEC_BITS];
    assign unused_adr = ^wbm_adr_i[31:16];
    // Indices at or above NUM_SLAVES produce no one-hot bit, which marks the access unmapped.
    assign hit        = |dec_oh;
    // The held one-hot cycle vector masks out responses from slaves that were not selected.
    assign s_ack      = |(wbs_ack_i & wbs_cyc_o);
    assign s_err      = |(wbs_err_i & wbs_cyc_o);
    assign wbs_stb_o  = wbs_cyc_o;
    always_comb begin
        dec_oh = '0;
        rd_dat = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            dec_oh[k] = dec_idx == DEC_BITS'(k);
            rd_dat    = rd_dat | (wbs_cyc_o[k] ? wbs_dat_i[16*k +: 16] : 16'h0);
        end
    end
`ifdef WBS_DECODER_TIMEOUT_EN
    wbs_timeout_cnt #(.TO_BITS(TO_BITS), .TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_n_i),
        .clr     (state != ST_BUSY),
        .en      (state == ST_BUSY),
        .expired (to_exp)
    );
`else
    assign to_exp = 1'b0;
`endif
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state     <= ST_IDLE;
            wbs_cyc_o <= '0;
            wbs_we_o  <= 1'b0;
            wbs_sel_o <= '0;
            wbs_adr_o <= '0;
            wbs_dat_o <= '0;
            wbm_dat_o <= '0;
            wbm_ack_o <= 1'b0;
            wbm_err_o <= 1'b0;
        end else begin
            wbm_ack_o <= 1'b0;
            wbm_err_o <= 1'b0;
            if (state == ST_IDLE && req) begin
                wbs_we_o  <= wbm_we_i;
                wbs_sel_o <= wbm_sel_i;
                wbs_adr_o <= wbm_adr_i[15:0];
                wbs_dat_o <= wbm_dat_i;
                wbs_cyc_o <= dec_oh;
                state     <= hit ? ST_BUSY : ST_ERR;
                wbm_err_o <= !hit;
            end else if (state == ST_BUSY && (s_ack || s_err || to_exp)) begin
                // A slave error beats its ack; a slave ack beats a simultaneous timeout.
                wbs_cyc_o <= '0;
                state     <= ST_IDLE;
                wbm_ack_o <= s_ack && !s_err;
                wbm_err_o <= s_err || !s_ack;
                if (s_ack && !s_err)
                    wbm_dat_o <= rd_dat;
            end else if (state != ST_BUSY) begin
                state <= ST_IDLE;
            end
        end
    end
endmodule
